// File: rtl/trg_sci_pkg.sv
// Shared definitions for the trigger science-data frame: sync word, length, byte offsets,
// decoded field bundle and parser states.
package trg_sci_pkg;

  localparam logic [15:0] SYNC_WORD = 16'hEB90;
  localparam int unsigned FRAME_LEN = 32;

  localparam logic [4:0] OFS_SYNC      = 5'd0;
  localparam logic [4:0] OFS_FRAME_CNT = 5'd2;
  localparam logic [4:0] OFS_LENGTH    = 5'd4;
  localparam logic [4:0] OFS_TIME_CODE = 5'd6;
  localparam logic [4:0] OFS_TAG       = 5'd12;
  localparam logic [4:0] OFS_MOD_TYPE  = 5'd13;
  localparam logic [4:0] OFS_PAD0      = 5'd14;
  localparam logic [4:0] OFS_OE        = 5'd15;
  localparam logic [4:0] OFS_HIT       = 5'd16;
  localparam logic [4:0] OFS_PAD1      = 5'd18;
  localparam logic [4:0] OFS_TRG_LOGIC = 5'd19;
  localparam logic [4:0] OFS_EFF_CNT   = 5'd20;
  localparam logic [4:0] OFS_BUSY      = 5'd22;
  localparam logic [4:0] OFS_COINCID   = 5'd25;
  localparam logic [4:0] OFS_RSVD      = 5'd26;
  localparam logic [4:0] OFS_CRC       = 5'd28;
  localparam logic [4:0] OFS_SUM       = 5'd30;
  localparam logic [4:0] OFS_LAST      = 5'd31;

  localparam logic [4:0] CRC_FIRST = 5'd12;
  localparam logic [4:0] CRC_LAST  = 5'd27;

  typedef enum logic [1:0] {StHunt, StSync1, StBody, StCheck} parser_state_e;

  typedef struct packed {
    logic [15:0] frame_cnt;
    logic [47:0] time_code;
    logic [7:0]  oe;
    logic [15:0] hit;
    logic [7:0]  trg_logic;
    logic [15:0] eff_trg_cnt;
    logic [23:0] busy_time;
    logic [5:0]  coincid_div;
  } sci_fields_t;

endpackage

// File: rtl/crc16_ccitt.sv
// CRC-16/CCITT (poly 0x1021, init 0xFFFF), one 16-bit word per enabled cycle, MSB first.
module crc16_ccitt (
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic [15:0] data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    for (int i = 15; i >= 0; i--) begin
      if (crc_d[15] ^ data_in[i]) crc_d = {crc_d[14:0], 1'b0} ^ 16'h1021;
      else                        crc_d = {crc_d[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         crc_q <= 16'hFFFF;
    else if (crc_en) crc_q <= crc_d;
  end

  assign crc_out = crc_q;

endmodule

// File: rtl/trg_sci_frame_parser.sv
// FIFO-draining parser for the 32-byte trigger science frame; CRC checking is present only
// when TRG_SCI_PARSER_CRC_EN is defined, otherwise pass/fail rests on the 16-bit sum.
module trg_sci_frame_parser #(
  parameter int unsigned FRAME_LEN = trg_sci_pkg::FRAME_LEN,
  parameter logic [15:0] SYNC_WORD = trg_sci_pkg::SYNC_WORD
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        parse_enb_in,
  input  logic        fifo_empty_in,
  input  logic [7:0]  fifo_data_in,
  output logic        fifo_rd_out,
  output logic        frame_valid_out,
  output logic [15:0] frame_cnt_out,
  output logic [47:0] time_code_out,
  output logic [7:0]  logic_grp_oe_out,
  output logic [15:0] hit_sig_stus_out,
  output logic [7:0]  trg_logic_out,
  output logic [15:0] eff_trg_cnt_out,
  output logic [23:0] busy_time_out,
  output logic [5:0]  coincid_div_out,
  output logic        crc_err_out,
  output logic        sum_err_out,
  output logic        len_err_out,
  output logic        sync_err_out,
  output logic [15:0] good_frame_cnt_out,
  output logic [15:0] err_frame_cnt_out,
  output logic [15:0] lost_frame_cnt_out
);
  import trg_sci_pkg::*;

  parser_state_e state_q;
  logic [4:0]    idx_q;      // index of the next byte to arrive while in StBody
  logic          rd_pend_q;  // a read was issued last cycle; its byte is on fifo_data_in
  logic [7:0]    hi_q;
  logic [15:0]   sum_q;
  logic          have_prev_q;
  sci_fields_t   shadow_q, fields_q;
  logic [15:0]   word;
  logic          in_body, last_req, sum_ok, crc_ok;

  assign word     = {hi_q, fifo_data_in};
  assign in_body  = rd_pend_q && (state_q == StBody);
  assign last_req = (state_q == StBody) && rd_pend_q && (idx_q == OFS_LAST);
  assign sum_ok   = (sum_q == word);

  assign fifo_rd_out = ~rst_in & parse_enb_in & ~fifo_empty_in & (state_q != StCheck) & ~last_req;

`ifdef TRG_SCI_PARSER_CRC_EN
  logic [15:0] crc_calc, rx_crc_q;
  logic        crc_en, crc_rst;

  assign crc_rst = rst_in | (state_q == StHunt);
  assign crc_en  = in_body && idx_q[0] && (idx_q > CRC_FIRST) && (idx_q <= CRC_LAST);

  crc16_ccitt u_crc (
    .clk     (clk_in),
    .rst     (crc_rst),
    .crc_en  (crc_en),
    .data_in (word),
    .crc_out (crc_calc)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in)                                     rx_crc_q <= '0;
    else if (in_body && idx_q == OFS_CRC + 5'd1) rx_crc_q <= word;
  end

  assign crc_ok = (crc_calc == rx_crc_q);
`else
  assign crc_ok = 1'b1;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q            <= StHunt;
      idx_q              <= '0;
      rd_pend_q          <= 1'b0;
      hi_q               <= '0;
      sum_q              <= '0;
      have_prev_q        <= 1'b0;
      shadow_q           <= '0;
      fields_q           <= '0;
      frame_valid_out    <= 1'b0;
      crc_err_out        <= 1'b0;
      sum_err_out        <= 1'b0;
      len_err_out        <= 1'b0;
      sync_err_out       <= 1'b0;
      good_frame_cnt_out <= '0;
      err_frame_cnt_out  <= '0;
      lost_frame_cnt_out <= '0;
    end else begin
      frame_valid_out <= 1'b0;
      crc_err_out     <= 1'b0;
      sum_err_out     <= 1'b0;
      len_err_out     <= 1'b0;
      sync_err_out    <= 1'b0;
      rd_pend_q       <= fifo_rd_out;
      unique case (state_q)
        StHunt: begin
          if (rd_pend_q && fifo_data_in == SYNC_WORD[15:8]) state_q <= StSync1;
        end
        StSync1: begin
          if (rd_pend_q) begin
            if (fifo_data_in == SYNC_WORD[7:0]) begin
              state_q <= StBody;
              idx_q   <= OFS_FRAME_CNT;
              sum_q   <= SYNC_WORD;
            end else if (fifo_data_in != SYNC_WORD[15:8]) begin
              sync_err_out <= 1'b1;
              state_q      <= StHunt;
            end
          end
        end
        StBody: begin
          if (rd_pend_q) begin
            hi_q  <= fifo_data_in;
            idx_q <= idx_q + 5'd1;
            if (idx_q[0] && idx_q <= OFS_CRC + 5'd1) sum_q <= sum_q + word;
            if (idx_q >= OFS_TIME_CODE && idx_q < OFS_TAG)
              shadow_q.time_code <= {shadow_q.time_code[39:0], fifo_data_in};
            if (idx_q >= OFS_BUSY && idx_q < OFS_COINCID)
              shadow_q.busy_time <= {shadow_q.busy_time[15:0], fifo_data_in};
            case (idx_q)
              OFS_FRAME_CNT + 5'd1: shadow_q.frame_cnt   <= word;
              OFS_OE:               shadow_q.oe          <= fifo_data_in;
              OFS_HIT + 5'd1:       shadow_q.hit         <= word;
              OFS_TRG_LOGIC:        shadow_q.trg_logic   <= fifo_data_in;
              OFS_EFF_CNT + 5'd1:   shadow_q.eff_trg_cnt <= word;
              OFS_COINCID:          shadow_q.coincid_div <= fifo_data_in[5:0];
              default: ;
            endcase
            if (idx_q == OFS_LENGTH + 5'd1 && word != 16'(FRAME_LEN)) begin
              len_err_out       <= 1'b1;
              err_frame_cnt_out <= err_frame_cnt_out + 16'd1;
              state_q           <= StHunt;
            end
            if (idx_q == OFS_LAST) begin
              state_q <= StCheck;
              if (sum_ok && crc_ok) begin
                frame_valid_out    <= 1'b1;
                fields_q           <= shadow_q;
                good_frame_cnt_out <= good_frame_cnt_out + 16'd1;
                have_prev_q        <= 1'b1;
                // fields_q still holds the previous good frame's counter here
                if (have_prev_q && shadow_q.frame_cnt != fields_q.frame_cnt + 16'd1 &&
                    lost_frame_cnt_out != 16'hFFFF)
                  lost_frame_cnt_out <= lost_frame_cnt_out + 16'd1;
              end else begin
                crc_err_out       <= ~crc_ok;
                sum_err_out       <= ~sum_ok;
                err_frame_cnt_out <= err_frame_cnt_out + 16'd1;
              end
            end
          end
        end
        StCheck: state_q <= StHunt;
        default: state_q <= StHunt;
      endcase
    end
  end

  assign frame_cnt_out    = fields_q.frame_cnt;
  assign time_code_out    = fields_q.time_code;
  assign logic_grp_oe_out = fields_q.oe;
  assign hit_sig_stus_out = fields_q.hit;
  assign trg_logic_out    = fields_q.trg_logic;
  assign eff_trg_cnt_out  = fields_q.eff_trg_cnt;
  assign busy_time_out    = fields_q.busy_time;
  assign coincid_div_out  = fields_q.coincid_div;

endmodule

// File: tb/tb_trg_sci_frame_parser.sv
// Directed bench: builds frames, feeds them through a FIFO model and checks decoded results.
module tb_trg_sci_frame_parser;

`ifdef TRG_SCI_PARSER_CRC_EN
  localparam int CRC_ON = 1;
`else
  localparam int CRC_ON = 0;
`endif

  logic clk = 1'b0;
  logic rst, enb, stall;
  logic fifo_empty, fifo_rd;
  logic [7:0] fifo_data = 8'h00;
  logic frame_valid, crc_err, sum_err, len_err, sync_err;
  logic [15:0] frame_cnt, hit, eff, good_cnt, err_cnt, lost_cnt;
  logic [47:0] time_code;
  logic [7:0]  oe, trg;
  logic [23:0] busy;
  logic [5:0]  coin;

  always #5 clk = ~clk;

  trg_sci_frame_parser dut (
    .clk_in             (clk),
    .rst_in             (rst),
    .parse_enb_in       (enb),
    .fifo_empty_in      (fifo_empty),
    .fifo_data_in       (fifo_data),
    .fifo_rd_out        (fifo_rd),
    .frame_valid_out    (frame_valid),
    .frame_cnt_out      (frame_cnt),
    .time_code_out      (time_code),
    .logic_grp_oe_out   (oe),
    .hit_sig_stus_out   (hit),
    .trg_logic_out      (trg),
    .eff_trg_cnt_out    (eff),
    .busy_time_out      (busy),
    .coincid_div_out    (coin),
    .crc_err_out        (crc_err),
    .sum_err_out        (sum_err),
    .len_err_out        (len_err),
    .sync_err_out       (sync_err),
    .good_frame_cnt_out (good_cnt),
    .err_frame_cnt_out  (err_cnt),
    .lost_frame_cnt_out (lost_cnt)
  );

  // FIFO model: data appears the cycle after the read strobe
  logic [7:0] mem [0:1023];
  int wr_ptr = 0, rd_ptr = 0, n_reads = 0, cyc = 0, last_rd = 0;
  assign fifo_empty = stall || (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd && !fifo_empty) begin
      fifo_data <= mem[rd_ptr[9:0]];
      rd_ptr    <= rd_ptr + 1;
      n_reads   <= n_reads + 1;
      last_rd   <= cyc;
    end
  end

  int n_valid = 0, n_crc = 0, n_sum = 0, n_len = 0, n_sync = 0, valid_cyc = 0;
  always @(negedge clk) begin
    if (frame_valid) begin
      n_valid   <= n_valid + 1;
      valid_cyc <= cyc;
    end
    if (crc_err)  n_crc  <= n_crc + 1;
    if (sum_err)  n_sum  <= n_sum + 1;
    if (len_err)  n_len  <= n_len + 1;
    if (sync_err) n_sync <= n_sync + 1;
  end

  int checks = 0, errors = 0;
  logic [7:0] fb [0:31];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic build(input logic [15:0] cnt, input logic [15:0] len, input logic [15:0] h,
                       input logic [23:0] b, input logic [5:0] c);
    logic [47:0] tc;
    logic [15:0] crc, sum;
    tc = 48'h0102_0304_0506;
    fb[0] = 8'hEB; fb[1] = 8'h90;
    fb[2] = cnt[15:8]; fb[3] = cnt[7:0];
    fb[4] = len[15:8]; fb[5] = len[7:0];
    for (int i = 0; i < 6; i++) fb[6+i] = tc[47-8*i -: 8];
    fb[12] = 8'h11; fb[13] = 8'h22; fb[14] = 8'h00; fb[15] = 8'h3C;
    fb[16] = h[15:8]; fb[17] = h[7:0]; fb[18] = 8'h00; fb[19] = 8'h81;
    fb[20] = 8'h12; fb[21] = 8'h34;
    fb[22] = b[23:16]; fb[23] = b[15:8]; fb[24] = b[7:0];
    fb[25] = {2'b00, c}; fb[26] = 8'h5C; fb[27] = 8'h3D;
    crc = 16'hFFFF;
    for (int i = 12; i < 28; i++) begin
      crc = crc ^ {fb[i], 8'h00};
      for (int k = 0; k < 8; k++) crc = crc[15] ? ((crc << 1) ^ 16'h1021) : (crc << 1);
    end
    fb[28] = crc[15:8]; fb[29] = crc[7:0];
    sum = 16'h0000;
    for (int i = 0; i < 30; i += 2) sum = sum + {fb[i], fb[i+1]};
    fb[30] = sum[15:8]; fb[31] = sum[7:0];
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem[wr_ptr[9:0]] = b;
    wr_ptr++;
  endtask

  task automatic push(input int first, input int last);
    for (int i = first; i <= last; i++) push_byte(fb[i]);
  endtask

  task automatic drain();
    int n = 0;
    while (rd_ptr != wr_ptr && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("fifo_drained", 64'(rd_ptr == wr_ptr), 64'd1);
    repeat (4) @(negedge clk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  int v0, r0, s0, c0, m0, l0;

  initial begin
    rst = 1'b1; enb = 1'b1; stall = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(frame_valid), 64'd0);
    chk("rst_rd", 64'(fifo_rd), 64'd0);
    chk("rst_good", 64'(good_cnt), 64'd0);
    chk("rst_err", 64'(err_cnt), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Clean frame, FIFO never empty
    v0 = n_valid; r0 = n_reads;
    build(16'h0005, 16'd32, 16'hA5A5, 24'h123456, 6'h2A);
    push(0, 31);
    drain();
    chk("t1_valid_pulses", 64'(n_valid - v0), 64'd1);
    chk("t1_reads", 64'(n_reads - r0), 64'd32);
    chk("t1_latency", 64'(valid_cyc - last_rd), 64'd2);
    chk("t1_frame_cnt", 64'(frame_cnt), 64'h0005);
    chk("t1_time_code", 64'(time_code), 64'h0102_0304_0506);
    chk("t1_oe", 64'(oe), 64'h3C);
    chk("t1_hit", 64'(hit), 64'hA5A5);
    chk("t1_trg", 64'(trg), 64'h81);
    chk("t1_eff", 64'(eff), 64'h1234);
    chk("t1_busy", 64'(busy), 64'h123456);
    chk("t1_coincid", 64'(coin), 64'h2A);
    chk("t1_good", 64'(good_cnt), 64'd1);
    chk("t1_err", 64'(err_cnt), 64'd0);

    // Sync hunting: EB 00 EB EB 90 ...
    v0 = n_valid; s0 = n_sync;
    push_byte(8'hEB); push_byte(8'h00); push_byte(8'hEB);
    build(16'h0006, 16'd32, 16'h1111, 24'h000001, 6'h01);
    push(0, 31);
    drain();
    chk("t2_sync_pulses", 64'(n_sync - s0), 64'd1);
    chk("t2_valid_pulses", 64'(n_valid - v0), 64'd1);
    chk("t2_frame_cnt", 64'(frame_cnt), 64'h0006);
    chk("t2_hit", 64'(hit), 64'h1111);
    chk("t2_lost", 64'(lost_cnt), 64'd0);

    // Corrupted byte 16, check words left stale
    v0 = n_valid; c0 = n_crc; m0 = n_sum;
    build(16'h0007, 16'd32, 16'hA5A5, 24'h123456, 6'h2A);
    fb[16] = 8'h5A;
    push(0, 31);
    drain();
    chk("t3_valid_pulses", 64'(n_valid - v0), 64'd0);
    chk("t3_crc_pulses", 64'(n_crc - c0), 64'(CRC_ON));
    chk("t3_sum_pulses", 64'(n_sum - m0), 64'd1);
    chk("t3_frame_cnt_held", 64'(frame_cnt), 64'h0006);
    chk("t3_hit_held", 64'(hit), 64'h1111);
    chk("t3_err", 64'(err_cnt), 64'd1);

    // Bad length, then a valid frame right behind it
    v0 = n_valid; l0 = n_len;
    build(16'h0008, 16'h0021, 16'h2222, 24'h000002, 6'h02);
    push(0, 5);
    build(16'h0007, 16'd32, 16'h3333, 24'h000003, 6'h03);
    push(0, 31);
    drain();
    chk("t4_len_pulses", 64'(n_len - l0), 64'd1);
    chk("t4_valid_pulses", 64'(n_valid - v0), 64'd1);
    chk("t4_err", 64'(err_cnt), 64'd2);
    chk("t4_good", 64'(good_cnt), 64'd3);
    chk("t4_frame_cnt", 64'(frame_cnt), 64'h0007);
    chk("t4_lost", 64'(lost_cnt), 64'd0);

    // Frame-count gaps and wrap
    build(16'h0009, 16'd32, 16'h4444, 24'h000004, 6'h04);
    push(0, 31);
    drain();
    chk("t5_lost_gap", 64'(lost_cnt), 64'd1);
    build(16'hFFFF, 16'd32, 16'h5555, 24'h000005, 6'h05);
    push(0, 31);
    drain();
    chk("t5_lost_gap2", 64'(lost_cnt), 64'd2);
    build(16'h0000, 16'd32, 16'h6666, 24'h000006, 6'h06);
    push(0, 31);
    drain();
    chk("t5_lost_wrap", 64'(lost_cnt), 64'd2);
    chk("t5_good", 64'(good_cnt), 64'd6);
    chk("t5_hit", 64'(hit), 64'h6666);

    // Stall after byte 20, reset mid-frame, then a fresh frame
    v0 = n_valid; c0 = n_crc; m0 = n_sum; l0 = n_len; s0 = n_sync;
    build(16'h1234, 16'd32, 16'h7777, 24'h000007, 6'h07);
    push(0, 20);
    drain();
    repeat (10) @(negedge clk);
    chk("t6_no_valid_stalled", 64'(n_valid - v0), 64'd0);
    chk("t6_good_stalled", 64'(good_cnt), 64'd6);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_rst_good", 64'(good_cnt), 64'd0);
    chk("t6_rst_lost", 64'(lost_cnt), 64'd0);
    chk("t6_rst_hit", 64'(hit), 64'd0);
    build(16'h0042, 16'd32, 16'h8888, 24'h000008, 6'h08);
    push(0, 31);
    drain();
    chk("t6_valid_pulses", 64'(n_valid - v0), 64'd1);
    chk("t6_err_pulses", 64'((n_crc - c0) + (n_sum - m0) + (n_len - l0) + (n_sync - s0)), 64'd0);
    chk("t6_good", 64'(good_cnt), 64'd1);
    chk("t6_err", 64'(err_cnt), 64'd0);
    chk("t6_lost", 64'(lost_cnt), 64'd0);
    chk("t6_frame_cnt", 64'(frame_cnt), 64'h0042);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
